// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the multi-channel stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10,
        LAP     = 2'b11
    } sw_state_t;

    // Widest counter the overflow helper can inspect.
    localparam int MAX_CNT_W = 64;

    // True when the low 'width' bits of cnt are all ones, i.e. the next increment overflows.
    function automatic logic f_ovf(input logic [MAX_CNT_W-1:0] cnt,
                                   input int                   width = MAX_CNT_W);
        logic [MAX_CNT_W-1:0] mask;
        mask = (width >= MAX_CNT_W) ? '1 : ((MAX_CNT_W'(1) << width) - MAX_CNT_W'(1));
        return (cnt & mask) == mask;
    endfunction

endpackage

// File: rtl/stopwatch_channel.sv
// One stopwatch channel: state machine, elapsed-tick counter, lap snapshot and sticky overflow.
module stopwatch_channel
    import stopwatch_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int WRAP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             reset,
    input  logic             lap,
    output sw_state_t        status,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] disp,
    output logic             ovf
);

    localparam bit SATURATE = (WRAP == 0);

    sw_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] snap_q, snap_d;
    logic             ovf_q, ovf_d;
    logic             inc, at_max, sat_hit;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        inc     = tick && (state_q == RUNNING || state_q == LAP);
        at_max  = f_ovf(MAX_CNT_W'(cnt_q), CNT_W);
        sat_hit = SATURATE && inc && at_max;

        state_d = state_q;
        cnt_d   = (inc && !sat_hit) ? cnt_q + CNT_W'(1) : cnt_q;
        snap_d  = snap_q;
        ovf_d   = ovf_q | (inc && at_max);

        unique case (state_q)
            IDLE: begin
                if (!reset && start) state_d = RUNNING;
            end
            RUNNING: begin
                if (reset)     state_d = IDLE;
                else if (stop) state_d = PAUSED;
                else if (lap)  state_d = LAP;
            end
            LAP: begin
                if (reset)     state_d = IDLE;
                else if (stop) state_d = PAUSED;
                else if (lap)  state_d = RUNNING;
            end
            PAUSED: begin
                if (reset)      state_d = IDLE;
                else if (start) state_d = RUNNING;
            end
            default: state_d = IDLE;
        endcase

        // Saturation pauses the channel on the same edge; only reset beats it.
        if (sat_hit && state_d != IDLE) state_d = PAUSED;

        if (state_q == RUNNING && state_d == LAP) snap_d = cnt_d;

        if (state_d == IDLE) begin
            cnt_d  = '0;
            snap_d = '0;
            ovf_d  = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            snap_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign status = state_q;
    assign count  = cnt_q;
    assign ovf    = ovf_q;
    assign disp   = (state_q == LAP) ? snap_q : cnt_q;

endmodule

// File: rtl/stopwatch_ctrl_multi.sv
// Multi-channel stopwatch controller: shared free-running tick prescaler feeding independent channels.
module stopwatch_ctrl_multi
    import stopwatch_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter int PRESCALE = 100,
    parameter int WRAP     = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       stop,
    input  logic [CHANNELS-1:0]       reset,
    input  logic [CHANNELS-1:0]       lap,
    output logic [2*CHANNELS-1:0]     status,
    output logic [CNT_W*CHANNELS-1:0] count,
    output logic [CNT_W*CHANNELS-1:0] disp,
    output logic [CHANNELS-1:0]       ovf,
    output logic                      tick
);

    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] psc_q;

    // With PRESCALE=1 the counter is pinned at 0, which equals PS_LAST, so tick stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) psc_q <= '0;
        else        psc_q <= (psc_q == PS_LAST) ? '0 : psc_q + PS_W'(1);
    end

    assign tick = (psc_q == PS_LAST);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        sw_state_t ch_status;

        stopwatch_channel #(
            .CNT_W (CNT_W),
            .WRAP  (WRAP)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .tick   (tick),
            .start  (start[i]),
            .stop   (stop[i]),
            .reset  (reset[i]),
            .lap    (lap[i]),
            .status (ch_status),
            .count  (count[CNT_W*i +: CNT_W]),
            .disp   (disp[CNT_W*i +: CNT_W]),
            .ovf    (ovf[i])
        );

        assign status[2*i +: 2] = ch_status;
    end

endmodule

// File: tb/tb_stopwatch_ctrl_multi.sv
// Bench for stopwatch_ctrl_multi: a wrapping and a saturating instance share stimulus and are
// checked every cycle against a behavioural model, with literal spot checks along the way.
module tb_stopwatch_ctrl_multi;

    localparam int CH       = 2;
    localparam int CW       = 4;
    localparam int PRESCALE = 3;
    localparam int MAXV     = 15;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_LAP   = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic [CH-1:0] start, stop, reset, lap;

    // Index 0: WRAP=1 instance, index 1: WRAP=0 instance.
    logic [1:0][2*CH-1:0]  st_v;
    logic [1:0][CW*CH-1:0] cnt_v;
    logic [1:0][CW*CH-1:0] dsp_v;
    logic [1:0][CH-1:0]    ovf_v;
    logic [1:0]            tick_v;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl_multi #(.CHANNELS(CH), .CNT_W(CW), .PRESCALE(PRESCALE), .WRAP(1)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .reset(reset), .lap(lap),
        .status(st_v[0]), .count(cnt_v[0]), .disp(dsp_v[0]), .ovf(ovf_v[0]), .tick(tick_v[0])
    );

    stopwatch_ctrl_multi #(.CHANNELS(CH), .CNT_W(CW), .PRESCALE(PRESCALE), .WRAP(0)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .reset(reset), .lap(lap),
        .status(st_v[1]), .count(cnt_v[1]), .disp(dsp_v[1]), .ovf(ovf_v[1]), .tick(tick_v[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int st;
        int cnt;
        int snap;
        bit ovf;
    } chan_t;

    chan_t m [2][CH];
    int    psc_m;
    logic  tick_m;

    assign tick_m = (psc_m == PRESCALE - 1);

    function automatic chan_t step(chan_t c, bit tk, bit wrap, bit s, bit sp, bit rs, bit lp);
        chan_t n = c;
        int    nst = c.st;
        bit    sat = 1'b0;
        if (tk && (c.st == S_RUN || c.st == S_LAP)) begin
            if (c.cnt == MAXV) begin
                n.ovf = 1'b1;
                if (wrap) n.cnt = 0;
                else      sat   = 1'b1;
            end else begin
                n.cnt = c.cnt + 1;
            end
        end
        case (c.st)
            S_IDLE:  if (!rs && s) nst = S_RUN;
            S_RUN:   nst = rs ? S_IDLE : sp ? S_PAUSE : lp ? S_LAP : S_RUN;
            S_LAP:   nst = rs ? S_IDLE : sp ? S_PAUSE : lp ? S_RUN : S_LAP;
            default: nst = rs ? S_IDLE : s ? S_RUN : S_PAUSE;
        endcase
        if (sat && nst != S_IDLE) nst = S_PAUSE;
        if (c.st == S_RUN && nst == S_LAP) n.snap = n.cnt;
        n.st = nst;
        if (nst == S_IDLE) begin
            n.cnt  = 0;
            n.snap = 0;
            n.ovf  = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_m <= 0;
            for (int i = 0; i < 2; i++)
                for (int c = 0; c < CH; c++)
                    m[i][c] <= '{default: 0};
        end else begin
            psc_m <= (psc_m + 1) % PRESCALE;
            for (int i = 0; i < 2; i++)
                for (int c = 0; c < CH; c++)
                    m[i][c] <= step(m[i][c], tick_m, (i == 0), start[c], stop[c], reset[c], lap[c]);
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < CH; c++) begin
                check($sformatf("cyc.i%0d.st%0d", i, c), 32'(st_v[i][2*c +: 2]), 32'(m[i][c].st));
                check($sformatf("cyc.i%0d.cnt%0d", i, c), 32'(cnt_v[i][CW*c +: CW]), 32'(m[i][c].cnt));
                check($sformatf("cyc.i%0d.disp%0d", i, c), 32'(dsp_v[i][CW*c +: CW]),
                      32'((m[i][c].st == S_LAP) ? m[i][c].snap : m[i][c].cnt));
                check($sformatf("cyc.i%0d.ovf%0d", i, c), 32'(ovf_v[i][c]), 32'(m[i][c].ovf));
            end
            check($sformatf("cyc.i%0d.tick", i), 32'(tick_v[i]), 32'(tick_m));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic cmd(input logic [CH-1:0] s, input logic [CH-1:0] sp,
                       input logic [CH-1:0] rs, input logic [CH-1:0] lp);
        start = s; stop = sp; reset = rs; lap = lp;
        cyc();
        start = '0; stop = '0; reset = '0; lap = '0;
    endtask

    task automatic tick_edges(input int n);
        int k = 0;
        int guard = 0;
        while (k < n && guard < 10 * n + 10) begin
            if (tick_m) k++;
            cyc();
            guard++;
        end
        check("tick_wait", 32'(k), 32'(n));
    endtask

    task automatic align_tick();
        int guard = 0;
        while (!tick_m && guard < 10) begin
            cyc();
            guard++;
        end
        check("align_tick", 32'(tick_m), 32'd1);
    endtask

    task automatic lit(input string tag, input int i, input int c,
                       input int est, input int ecnt, input int edsp, input int eov);
        check($sformatf("%s.i%0d.st%0d", tag, i, c), 32'(st_v[i][2*c +: 2]), 32'(est));
        check($sformatf("%s.i%0d.cnt%0d", tag, i, c), 32'(cnt_v[i][CW*c +: CW]), 32'(ecnt));
        check($sformatf("%s.i%0d.disp%0d", tag, i, c), 32'(dsp_v[i][CW*c +: CW]), 32'(edsp));
        check($sformatf("%s.i%0d.ovf%0d", tag, i, c), 32'(ovf_v[i][c]), 32'(eov));
    endtask

    task automatic lit_both(input string tag, input int c,
                            input int est, input int ecnt, input int edsp, input int eov);
        lit(tag, 0, c, est, ecnt, edsp, eov);
        lit(tag, 1, c, est, ecnt, edsp, eov);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        start = '0; stop = '0; reset = '0; lap = '0;
        #1 rst_n = 1'b0;
        #1;
        for (int c = 0; c < CH; c++) lit_both("por", c, 0, 0, 0, 0);
        check("por.tick0", 32'(tick_v[0]), 32'd0);
        check("por.tick1", 32'(tick_v[1]), 32'd0);
        #10 rst_n = 1'b1;
        cyc();

        // Start / pause / resume
        cmd(2'b01, 2'b00, 2'b00, 2'b00);
        tick_edges(5);
        lit_both("run5", 0, S_RUN, 5, 5, 0);
        cmd(2'b00, 2'b01, 2'b00, 2'b00);
        lit_both("stop", 0, S_PAUSE, 5, 5, 0);
        tick_edges(10);
        lit_both("hold", 0, S_PAUSE, 5, 5, 0);
        cmd(2'b01, 2'b00, 2'b00, 2'b00);
        tick_edges(1);
        lit_both("resume", 0, S_RUN, 6, 6, 0);

        // Lap freeze, release, and capture on a tick edge
        cmd(2'b00, 2'b00, 2'b01, 2'b00);
        lit_both("rst0", 0, S_IDLE, 0, 0, 0);
        cmd(2'b01, 2'b00, 2'b00, 2'b00);
        tick_edges(3);
        cmd(2'b00, 2'b00, 2'b00, 2'b01);
        lit_both("lap_in", 0, S_LAP, 3, 3, 0);
        tick_edges(4);
        lit_both("lap_hold", 0, S_LAP, 7, 3, 0);
        cmd(2'b00, 2'b00, 2'b00, 2'b01);
        lit_both("lap_out", 0, S_RUN, 7, 7, 0);
        align_tick();
        cmd(2'b00, 2'b00, 2'b00, 2'b01);
        lit_both("lap_tick", 0, S_LAP, 8, 8, 0);
        cmd(2'b00, 2'b00, 2'b00, 2'b01);

        // Overflow: wrap vs. saturate
        tick_edges(7);
        lit_both("at_max", 0, S_RUN, 15, 15, 0);
        tick_edges(1);
        lit("wrap", 0, 0, S_RUN, 0, 0, 1);
        lit("sat", 1, 0, S_PAUSE, 15, 15, 1);
        cmd(2'b01, 2'b00, 2'b00, 2'b00);
        lit("sat_restart", 1, 0, S_RUN, 15, 15, 1);
        tick_edges(1);
        lit("wrap_after", 0, 0, S_RUN, 1, 1, 1);
        lit("resat", 1, 0, S_PAUSE, 15, 15, 1);
        cmd(2'b00, 2'b00, 2'b01, 2'b00);
        lit_both("ovf_clr", 0, S_IDLE, 0, 0, 0);

        // Simultaneous events and channel independence
        cmd(2'b01, 2'b00, 2'b00, 2'b00);
        tick_edges(2);
        cmd(2'b00, 2'b01, 2'b01, 2'b00);
        lit_both("stop_rst", 0, S_IDLE, 0, 0, 0);
        cmd(2'b01, 2'b00, 2'b00, 2'b00);
        tick_edges(1);
        align_tick();
        cmd(2'b00, 2'b01, 2'b00, 2'b00);
        lit_both("stop_tick", 0, S_PAUSE, 2, 2, 0);
        cmd(2'b10, 2'b00, 2'b00, 2'b00);
        tick_edges(3);
        lit_both("ch1_run", 1, S_RUN, 3, 3, 0);
        lit_both("ch0_idle", 0, S_PAUSE, 2, 2, 0);
        cmd(2'b01, 2'b00, 2'b00, 2'b10);
        lit_both("mix_ch0", 0, S_RUN, 2, 2, 0);
        lit_both("mix_ch1", 1, S_LAP, 3, 3, 0);
        tick_edges(2);
        lit_both("indep_ch0", 0, S_RUN, 4, 4, 0);
        lit_both("indep_ch1", 1, S_LAP, 5, 3, 0);

        // Asynchronous reset mid-cycle with both channels in LAP at 9
        cmd(2'b00, 2'b00, 2'b11, 2'b00);
        cmd(2'b11, 2'b00, 2'b00, 2'b00);
        tick_edges(9);
        cmd(2'b00, 2'b00, 2'b00, 2'b11);
        for (int c = 0; c < CH; c++) lit_both("pre_arst", c, S_LAP, 9, 9, 0);
        #1 rst_n = 1'b0;
        #1;
        for (int c = 0; c < CH; c++) lit_both("arst", c, S_IDLE, 0, 0, 0);
        check("arst.tick0", 32'(tick_v[0]), 32'd0);
        #2 rst_n = 1'b1;
        #1;
        check("rel.tick_e0", 32'(tick_v[0]), 32'd0);
        cyc();
        check("rel.tick_e1", 32'(tick_v[0]), 32'd0);
        cyc();
        check("rel.tick_e2", 32'(tick_v[0]), 32'd1);
        check("rel.tick_e2s", 32'(tick_v[1]), 32'd1);
        lit_both("rel", 0, S_IDLE, 0, 0, 0);
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
